// File: rtl/soc_irq_router.sv
// soc_irq_router
//   Routes NUM_SRC peripheral interrupt lines to NUM_TGT CPU interrupt inputs.
//   Every source has a run-time configuration word: enable, level/edge mode,
//   priority and target index. Each target presents the highest-priority
//   pending source routed to it, using a valid/ack claim handshake.
//
// Ports
//   clk_sys    in   1              system clock (single domain)
//   rst_sys    in   1              synchronous, active-high reset
//   irq_src    in   NUM_SRC        raw interrupt lines, bit i = source i
//   cfg_we     in   1              configuration write strobe
//   cfg_idx    in   SRC_W          source index being configured
//   cfg_wdata  in   CFG_W          {tgt, prio, edge, en}
//   irq_tgt    out  NUM_TGT        per-target request valid
//   irq_id     out  NUM_TGT*SRC_W  per-target presented source ID
//   irq_ack    in   NUM_TGT        per-target claim, honoured while irq_tgt is high
module soc_irq_router #(
  parameter int NUM_SRC = 64,
  parameter int NUM_TGT = 8,
  parameter int PRIO_W  = 3,
  localparam int SRC_W  = $clog2(NUM_SRC),
  localparam int TGT_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1,
  localparam int CFG_W  = 2 + PRIO_W + TGT_W
) (
  input  logic                       clk_sys,
  input  logic                       rst_sys,
  input  logic [NUM_SRC-1:0]         irq_src,
  input  logic                       cfg_we,
  input  logic [SRC_W-1:0]           cfg_idx,
  input  logic [CFG_W-1:0]           cfg_wdata,
  output logic [NUM_TGT-1:0]         irq_tgt,
  output logic [NUM_TGT*SRC_W-1:0]   irq_id,
  input  logic [NUM_TGT-1:0]         irq_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_CLAIMED = 2'd2
  } state_e;

  // Per-source configuration and status
  logic [NUM_SRC-1:0] en_r;
  logic [NUM_SRC-1:0] edge_r;
  logic [PRIO_W-1:0]  prio_r [NUM_SRC];
  logic [TGT_W-1:0]   tgt_r  [NUM_SRC];
  logic [NUM_SRC-1:0] src_q_r;
  logic [NUM_SRC-1:0] pend_r;

  logic [NUM_SRC-1:0] pend_nxt_s;
  logic [NUM_SRC-1:0] cfg_hit_s;
  logic [NUM_SRC-1:0] claim_s;

  // Per-target arbitration and presentation
  logic [NUM_SRC-1:0] cand_s      [NUM_TGT];
  logic [NUM_TGT-1:0] found_s;
  logic [NUM_TGT-1:0] keep_s;
  logic [SRC_W-1:0]   win_id_s    [NUM_TGT];
  logic [PRIO_W-1:0]  best_prio_s [NUM_TGT];

  state_e             state_r  [NUM_TGT];
  logic [NUM_TGT-1:0] irq_tgt_r;
  logic [SRC_W-1:0]   irq_id_r [NUM_TGT];

  // Claim decode: a source is claimed when any target acks while presenting it
  always_comb begin
    claim_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        claim_s[i] = claim_s[i] |
                     (irq_ack[t] & irq_tgt_r[t] & (irq_id_r[t] == SRC_W'(i)));
      end
    end
  end

  // Next pending state: disable clears, edge mode latches until claimed, level follows the line
  always_comb begin
    cfg_hit_s  = '0;
    pend_nxt_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Index compare per source means out-of-range cfg_idx simply hits nothing
      cfg_hit_s[i] = cfg_we & (cfg_idx == SRC_W'(i));
      if (cfg_hit_s[i] && !cfg_wdata[0]) begin
        pend_nxt_s[i] = 1'b0;
      end else if (edge_r[i]) begin
        // A new rising edge wins over a simultaneous claim
        pend_nxt_s[i] = (irq_src[i] & ~src_q_r[i] & en_r[i]) |
                        (pend_r[i] & ~claim_s[i]);
      end else begin
        pend_nxt_s[i] = irq_src[i] & en_r[i] & ~claim_s[i];
      end
    end
  end

  // Per-target arbitration: highest prio wins, ascending scan keeps the lowest index on ties
  always_comb begin : p_arb
    logic take;
    take = 1'b0;
    for (int t = 0; t < NUM_TGT; t++) begin
      found_s[t]     = 1'b0;
      keep_s[t]      = 1'b0;
      win_id_s[t]    = '0;
      best_prio_s[t] = '0;
      cand_s[t]      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        // Targets >= NUM_TGT never match any t, so such sources route nowhere
        cand_s[t][i]   = pend_r[i] & en_r[i] & (tgt_r[i] == TGT_W'(t));
        take           = cand_s[t][i] & (~found_s[t] | (prio_r[i] > best_prio_s[t]));
        win_id_s[t]    = take ? SRC_W'(i) : win_id_s[t];
        best_prio_s[t] = take ? prio_r[i] : best_prio_s[t];
        found_s[t]     = found_s[t] | take;
        // Is the currently presented source still a candidate for this target?
        keep_s[t]      = keep_s[t] | (cand_s[t][i] & (irq_id_r[t] == SRC_W'(i)));
      end
    end
  end

  // Source state: configuration words, previous line sample and pending bits
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      en_r    <= '0;
      edge_r  <= '0;
      src_q_r <= '0;
      pend_r  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_r[i] <= '0;
        tgt_r[i]  <= '0;
      end
    end else begin
      src_q_r <= irq_src;
      pend_r  <= pend_nxt_s;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_hit_s[i]) begin
          en_r[i]   <= cfg_wdata[0];
          edge_r[i] <= cfg_wdata[1];
          prio_r[i] <= cfg_wdata[PRIO_W+1:2];
          tgt_r[i]  <= cfg_wdata[CFG_W-1:PRIO_W+2];
        end
      end
    end
  end

  // Presentation FSM per target with registered irq_tgt / irq_id
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      irq_tgt_r <= '0;
      for (int t = 0; t < NUM_TGT; t++) begin
        state_r[t]  <= ST_IDLE;
        irq_id_r[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TGT; t++) begin
        case (state_r[t])
          ST_IDLE: begin
            if (found_s[t]) begin
              irq_id_r[t]  <= win_id_s[t];
              irq_tgt_r[t] <= 1'b1;
              state_r[t]   <= ST_PRESENT;
            end else begin
              irq_tgt_r[t] <= 1'b0;
            end
          end
          ST_PRESENT: begin
            // ID is held: no preemption, only ack or withdrawal leave this state
            if (irq_ack[t]) begin
              irq_tgt_r[t] <= 1'b0;
              state_r[t]   <= ST_CLAIMED;
            end else if (!keep_s[t]) begin
              irq_tgt_r[t] <= 1'b0;
              state_r[t]   <= ST_IDLE;
            end else begin
              irq_tgt_r[t] <= 1'b1;
            end
          end
          ST_CLAIMED: begin
            // Bubble cycle so the claimed pending clear is visible before re-arbitration
            irq_tgt_r[t] <= 1'b0;
            state_r[t]   <= ST_IDLE;
          end
          default: begin
            irq_tgt_r[t] <= 1'b0;
            state_r[t]   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign irq_tgt = irq_tgt_r;

  // Flatten presented IDs onto the output bus
  always_comb begin
    irq_id = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      irq_id[t*SRC_W +: SRC_W] = irq_id_r[t];
    end
  end

endmodule

// File: tb/tb_soc_irq_router.sv
// Testbench for soc_irq_router (default parameters: 64 sources, 8 targets, 3-bit prio).
// Directed scenarios check hand-derived values; a random phase compares every
// cycle against a behavioural model of the routing rules.
module tb_soc_irq_router;

  localparam int NS = 64;
  localparam int NT = 8;

  logic          clk_sys = 1'b0;
  logic          rst_sys;
  logic [63:0]   irq_src;
  logic          cfg_we;
  logic [5:0]    cfg_idx;
  logic [7:0]    cfg_wdata;
  logic [7:0]    irq_tgt;
  logic [47:0]   irq_id;
  logic [7:0]    irq_ack;

  int n_vec = 0;
  int n_err = 0;

  soc_irq_router #(.NUM_SRC(64), .NUM_TGT(8), .PRIO_W(3)) dut (
    .clk_sys   (clk_sys),
    .rst_sys   (rst_sys),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .irq_tgt   (irq_tgt),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural model: per-source config and pending, per-target "showing" flag,
  // shown ID and a one-cycle cool-down after a claim.
  bit m_en[NS], m_edge[NS], m_pend[NS], m_prev[NS];
  int m_prio[NS], m_tgt[NS];
  bit m_show[NT], m_cool[NT];
  int m_id[NT];

  function automatic logic [7:0] exp_tgt();
    logic [7:0] v;
    for (int t = 0; t < NT; t++) v[t] = m_show[t];
    return v;
  endfunction

  function automatic logic [47:0] exp_id();
    logic [47:0] v;
    for (int t = 0; t < NT; t++) v[t*6 +: 6] = 6'(m_id[t]);
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit np[NS];
    bit clm[NS];
    bit ns[NT], nc[NT];
    int nid[NT];
    int best, bid, score;
    if (rst_sys) begin
      for (int i = 0; i < NS; i++) begin
        m_en[i] = 0; m_edge[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
        m_prio[i] = 0; m_tgt[i] = 0;
      end
      for (int t = 0; t < NT; t++) begin
        m_show[t] = 0; m_cool[t] = 0; m_id[t] = 0;
      end
      return;
    end
    for (int i = 0; i < NS; i++) clm[i] = 0;
    for (int t = 0; t < NT; t++) if (m_show[t] && irq_ack[t]) clm[m_id[t]] = 1;
    for (int i = 0; i < NS; i++) begin
      if (cfg_we && int'(cfg_idx) == i && !cfg_wdata[0]) np[i] = 0;
      else if (m_edge[i]) np[i] = (irq_src[i] && !m_prev[i] && m_en[i]) || (m_pend[i] && !clm[i]);
      else np[i] = irq_src[i] && m_en[i] && !clm[i];
    end
    for (int t = 0; t < NT; t++) begin
      ns[t] = m_show[t]; nc[t] = 0; nid[t] = m_id[t];
      if (m_show[t]) begin
        if (irq_ack[t]) begin ns[t] = 0; nc[t] = 1; end
        else if (!(m_pend[m_id[t]] && m_en[m_id[t]] && m_tgt[m_id[t]] == t)) ns[t] = 0;
      end else if (!m_cool[t]) begin
        best = -1; bid = 0;
        for (int i = 0; i < NS; i++) begin
          score = m_prio[i] * NS + (NS - 1 - i);
          if (m_pend[i] && m_en[i] && m_tgt[i] == t && score > best) begin
            best = score; bid = i;
          end
        end
        if (best >= 0) begin ns[t] = 1; nid[t] = bid; end
      end
    end
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = np[i];
      m_prev[i] = irq_src[i];
    end
    for (int t = 0; t < NT; t++) begin
      m_show[t] = ns[t]; m_cool[t] = nc[t]; m_id[t] = nid[t];
    end
    if (cfg_we) begin
      m_en[cfg_idx]   = cfg_wdata[0];
      m_edge[cfg_idx] = cfg_wdata[1];
      m_prio[cfg_idx] = int'(cfg_wdata[4:2]);
      m_tgt[cfg_idx]  = int'(cfg_wdata[7:5]);
    end
  endtask

  // One clock: update model, pass the edge, settle before inputs change
  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_cfg(input logic [5:0] idx, input logic en, input logic edg,
                         input logic [2:0] prio, input logic [2:0] tgt);
    cfg_we = 1'b1; cfg_idx = idx; cfg_wdata = {tgt, prio, edg, en};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    irq_src = 64'd0; irq_ack = 8'd0; cfg_we = 1'b0; cfg_idx = 6'd0; cfg_wdata = 8'd0;
    rst_sys = 1'b1;
    tick(); tick();
    rst_sys = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (irq_tgt !== 8'h00 || irq_id !== 48'd0) begin
      n_err++;
      $display("FAIL reset: irq_tgt=%h irq_id=%h, required 00 / 0", irq_tgt, irq_id);
    end
  endtask

  task automatic test_level_basic();
    do_reset();
    set_cfg(6'd5, 1'b1, 1'b0, 3'd2, 3'd0);
    irq_src[5] = 1'b1;
    tick();
    n_vec++;
    if (irq_tgt !== 8'h00) begin
      n_err++; $display("FAIL level_latency1: irq_tgt=%h, required 00", irq_tgt);
    end
    tick();
    n_vec++;
    if (irq_tgt !== 8'h01 || irq_id[5:0] !== 6'd5) begin
      n_err++; $display("FAIL level_present: irq_tgt=%h id0=%0d, required 01 / 5", irq_tgt, irq_id[5:0]);
    end
  endtask

  task automatic test_edge_priority();
    do_reset();
    set_cfg(6'd3, 1'b1, 1'b1, 3'd1, 3'd1);
    set_cfg(6'd9, 1'b1, 1'b1, 3'd4, 3'd1);
    irq_src[3] = 1'b1; irq_src[9] = 1'b1;
    tick();
    irq_src[3] = 1'b0; irq_src[9] = 1'b0;
    tick();
    n_vec++;
    if (irq_tgt !== 8'h02 || irq_id[11:6] !== 6'd9) begin
      n_err++; $display("FAIL edge_first: irq_tgt=%h id1=%0d, required 02 / 9", irq_tgt, irq_id[11:6]);
    end
    irq_ack[1] = 1'b1; tick(); irq_ack[1] = 1'b0;
    n_vec++;
    if (irq_tgt !== 8'h00) begin
      n_err++; $display("FAIL edge_claim: irq_tgt=%h, required 00", irq_tgt);
    end
    tick();
    n_vec++;
    if (irq_tgt !== 8'h00 || irq_id[11:6] !== 6'd9) begin
      n_err++; $display("FAIL edge_bubble: irq_tgt=%h id1=%0d, required 00 / 9", irq_tgt, irq_id[11:6]);
    end
    tick();
    n_vec++;
    if (irq_tgt !== 8'h02 || irq_id[11:6] !== 6'd3) begin
      n_err++; $display("FAIL edge_second: irq_tgt=%h id1=%0d, required 02 / 3", irq_tgt, irq_id[11:6]);
    end
    irq_ack[1] = 1'b1; tick(); irq_ack[1] = 1'b0;
    tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'h00) begin
      n_err++; $display("FAIL edge_drained: irq_tgt=%h, required 00", irq_tgt);
    end
  endtask

  task automatic test_tie_no_preempt();
    do_reset();
    set_cfg(6'd10, 1'b1, 1'b0, 3'd3, 3'd2);
    set_cfg(6'd20, 1'b1, 1'b0, 3'd3, 3'd2);
    set_cfg(6'd30, 1'b1, 1'b0, 3'd7, 3'd2);
    irq_src[10] = 1'b1; irq_src[20] = 1'b1;
    tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'h04 || irq_id[17:12] !== 6'd10) begin
      n_err++; $display("FAIL tie_lowest: irq_tgt=%h id2=%0d, required 04 / 10", irq_tgt, irq_id[17:12]);
    end
    irq_src[30] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (irq_tgt !== 8'h04 || irq_id[17:12] !== 6'd10) begin
        n_err++; $display("FAIL no_preempt: irq_tgt=%h id2=%0d, required 04 / 10", irq_tgt, irq_id[17:12]);
      end
    end
    irq_ack[2] = 1'b1; tick(); irq_ack[2] = 1'b0;
    tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'h04 || irq_id[17:12] !== 6'd30) begin
      n_err++; $display("FAIL after_ack_high: irq_tgt=%h id2=%0d, required 04 / 30", irq_tgt, irq_id[17:12]);
    end
  endtask

  task automatic test_edge_claim_collision();
    do_reset();
    set_cfg(6'd7, 1'b1, 1'b1, 3'd1, 3'd4);
    irq_src[7] = 1'b1; tick();
    irq_src[7] = 1'b0; tick();
    n_vec++;
    if (irq_tgt !== 8'h10 || irq_id[29:24] !== 6'd7) begin
      n_err++; $display("FAIL coll_present: irq_tgt=%h id4=%0d, required 10 / 7", irq_tgt, irq_id[29:24]);
    end
    irq_src[7] = 1'b1; irq_ack[4] = 1'b1;
    tick();
    irq_ack[4] = 1'b0;
    tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'h10 || irq_id[29:24] !== 6'd7) begin
      n_err++; $display("FAIL coll_repost: irq_tgt=%h id4=%0d, required 10 / 7", irq_tgt, irq_id[29:24]);
    end
    irq_ack[4] = 1'b1; tick(); irq_ack[4] = 1'b0;
    tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'h00) begin
      n_err++; $display("FAIL coll_single: irq_tgt=%h, required 00", irq_tgt);
    end
  endtask

  task automatic test_withdrawal();
    do_reset();
    set_cfg(6'd4, 1'b1, 1'b0, 3'd5, 3'd3);
    irq_src[4] = 1'b1; tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'h08 || irq_id[23:18] !== 6'd4) begin
      n_err++; $display("FAIL wd_present: irq_tgt=%h id3=%0d, required 08 / 4", irq_tgt, irq_id[23:18]);
    end
    irq_src[4] = 1'b0; tick();
    n_vec++;
    if (irq_tgt !== 8'h08) begin
      n_err++; $display("FAIL wd_drop_k: irq_tgt=%h, required 08", irq_tgt);
    end
    tick();
    n_vec++;
    if (irq_tgt !== 8'h00 || irq_id[23:18] !== 6'd4) begin
      n_err++; $display("FAIL wd_drop_k1: irq_tgt=%h id3=%0d, required 00 / 4", irq_tgt, irq_id[23:18]);
    end
    irq_src[4] = 1'b1; tick(); tick();
    set_cfg(6'd4, 1'b0, 1'b0, 3'd5, 3'd3);
    n_vec++;
    if (irq_tgt !== 8'h08) begin
      n_err++; $display("FAIL wd_dis_k: irq_tgt=%h, required 08", irq_tgt);
    end
    tick();
    n_vec++;
    if (irq_tgt !== 8'h00) begin
      n_err++; $display("FAIL wd_dis_k1: irq_tgt=%h, required 00", irq_tgt);
    end
    tick();
    n_vec++;
    if (irq_tgt !== 8'h00) begin
      n_err++; $display("FAIL wd_dis_stay: irq_tgt=%h, required 00", irq_tgt);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_cfg(6'd1, 1'b1, 1'b0, 3'd1, 3'd5);
    set_cfg(6'd2, 1'b1, 1'b0, 3'd2, 3'd6);
    set_cfg(6'd3, 1'b1, 1'b1, 3'd3, 3'd7);
    irq_src[1] = 1'b1; irq_src[2] = 1'b1; irq_src[3] = 1'b1;
    tick(); tick();
    n_vec++;
    if (irq_tgt !== 8'hE0) begin
      n_err++; $display("FAIL rst_pre: irq_tgt=%h, required e0", irq_tgt);
    end
    rst_sys = 1'b1; tick(); rst_sys = 1'b0;
    n_vec++;
    if (irq_tgt !== 8'h00 || irq_id !== 48'd0) begin
      n_err++; $display("FAIL rst_mid: irq_tgt=%h irq_id=%h, required 00 / 0", irq_tgt, irq_id);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (irq_tgt !== 8'h00) begin
        n_err++; $display("FAIL rst_stay: irq_tgt=%h, required 00", irq_tgt);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] flip;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_sys = ($urandom_range(0, 599) == 0);
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_idx = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 11));
      cfg_wdata    = 8'($urandom);
      cfg_wdata[0] = ($urandom_range(0, 3) != 0);
      cfg_wdata[7:5] = 3'($urandom_range(0, 3));
      flip = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      irq_src = irq_src ^ flip;
      irq_ack = 8'($urandom) & 8'($urandom);
      tick();
      n_vec++;
      if (irq_tgt !== exp_tgt() || irq_id !== exp_id()) begin
        n_err++;
        $display("FAIL random cyc %0d: irq_tgt=%h irq_id=%h, required %h / %h",
                 n, irq_tgt, irq_id, exp_tgt(), exp_id());
      end
    end
    rst_sys = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level_basic();
    test_edge_priority();
    test_tie_no_preempt();
    test_edge_claim_collision();
    test_withdrawal();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
